// File: rtl/card_click_if.sv
// Click-controller bus: mouse and enable inputs, card-state regfile read port,
// and pick outputs toward the game logic.
interface card_click_if #(
  parameter int ADDR_W = 5
);
  logic              en;
  logic              mouse_left;
  logic [11:0]       mouse_xpos;
  logic [11:0]       mouse_ypos;
  logic              clear_pair;
  logic [1:0]        test_state;
  logic [ADDR_W-1:0] test_addr;
  logic              pick_valid;
  logic [ADDR_W-1:0] pick_addr;
  logic              pick_second;
  logic              busy;

  modport master (
    output en, mouse_left, mouse_xpos, mouse_ypos, clear_pair, test_state,
    input  test_addr, pick_valid, pick_addr, pick_second, busy
  );

  modport slave (
    input  en, mouse_left, mouse_xpos, mouse_ypos, clear_pair, test_state,
    output test_addr, pick_valid, pick_addr, pick_second, busy
  );
endinterface

// File: rtl/card_click_ctl.sv
// Maps a mouse click to a card on a grid by scanning one card per cycle and emits picks in pairs.
// Optional macro CARD_CLICK_SAME_GUARD_EN rejects a second pick of the same card.
module card_click_ctl #(
  parameter int CARDS  = 18,
  parameter int COLS   = 6,
  parameter int ADDR_W = 5,
  parameter int CARD_W = 100,
  parameter int CARD_H = 150,
  parameter int GAP    = 20,
  parameter int X0     = 50,
  parameter int Y0     = 55
) (
  input  logic         clk,
  input  logic         rst,
  card_click_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SCAN, CHECK, EMIT, WAIT_CLEAR} state_t;

  localparam logic [12:0]       CW       = 13'(CARD_W);
  localparam logic [12:0]       CH       = 13'(CARD_H);
  localparam logic [12:0]       STEP_X   = 13'(CARD_W + GAP);
  localparam logic [12:0]       STEP_Y   = 13'(CARD_H + GAP);
  localparam logic [12:0]       ORG_X    = 13'(X0);
  localparam logic [12:0]       ORG_Y    = 13'(Y0);
  localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(CARDS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);

  state_t            state, next;
  logic              prev_left;
  logic              pair_flag;
  logic [11:0]       lx, ly;
  logic [ADDR_W-1:0] k, col;
  logic [12:0]       ox, oy;
  logic [ADDR_W-1:0] test_addr_r, pick_addr_r;
  logic              pick_valid_r, pick_second_r;
  logic              busy_c;
  logic              click, hit, same_reject, accept;

  assign click = bus.mouse_left & ~prev_left;

  // Origins are 13 bits wide so the right/bottom edge never wraps.
  assign hit = ({1'b0, lx} >= ox) && ({1'b0, lx} < ox + CW) &&
               ({1'b0, ly} >= oy) && ({1'b0, ly} < oy + CH);

`ifdef CARD_CLICK_SAME_GUARD_EN
  assign same_reject = pair_flag && (test_addr_r == pick_addr_r);
`else
  assign same_reject = 1'b0;
`endif

  assign accept = (bus.test_state == 2'b01) && !same_reject;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    if (!bus.en) begin
      next = IDLE;
    end else begin
      case (state)
        IDLE:       if (click) next = SCAN;
        SCAN:       if (hit) next = CHECK;
                    else if (k == LAST_K) next = IDLE;
        CHECK:      next = accept ? EMIT : IDLE;
        EMIT:       next = pair_flag ? WAIT_CLEAR : IDLE;
        WAIT_CLEAR: if (bus.clear_pair) next = IDLE;
        default:    next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_c = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_left     <= 1'b0;
      pair_flag     <= 1'b0;
      lx            <= '0;
      ly            <= '0;
      k             <= '0;
      col           <= '0;
      ox            <= '0;
      oy            <= '0;
      test_addr_r   <= '0;
      pick_addr_r   <= '0;
      pick_valid_r  <= 1'b0;
      pick_second_r <= 1'b0;
    end else begin
      prev_left    <= bus.mouse_left;
      pick_valid_r <= 1'b0;
      if (!bus.en) begin
        pair_flag <= 1'b0;
      end else begin
        case (state)
          IDLE: if (click) begin
            lx  <= bus.mouse_xpos;
            ly  <= bus.mouse_ypos;
            k   <= '0;
            col <= '0;
            ox  <= ORG_X;
            oy  <= ORG_Y;
          end
          SCAN: begin
            if (hit) begin
              test_addr_r <= k + ADDR_W'(1);
            end else begin
              k <= k + ADDR_W'(1);
              // Row wrap: step the Y origin and rewind X instead of multiplying.
              if (col == LAST_COL) begin
                col <= '0;
                ox  <= ORG_X;
                oy  <= oy + STEP_Y;
              end else begin
                col <= col + ADDR_W'(1);
                ox  <= ox + STEP_X;
              end
            end
          end
          EMIT: begin
            pick_valid_r  <= 1'b1;
            pick_addr_r   <= test_addr_r;
            pick_second_r <= pair_flag;
            pair_flag     <= 1'b1;
          end
          WAIT_CLEAR: if (bus.clear_pair) pair_flag <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign bus.test_addr   = test_addr_r;
  assign bus.pick_valid  = pick_valid_r;
  assign bus.pick_addr   = pick_addr_r;
  assign bus.pick_second = pick_second_r;
  assign bus.busy        = busy_c;

endmodule

// File: tb/tb_card_click_ctl.sv
// Directed bench for card_click_ctl with default geometry; checks with immediate assertions.
module tb_card_click_ctl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc;
  int   busy_cnt;
  int   pv_cnt;
  logic [1:0] tab [0:31];

  always #5 clk = ~clk;

  card_click_if #(.ADDR_W(5)) bus ();

  card_click_ctl #(.CARDS(18), .COLS(6), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always_comb bus.test_state = tab[bus.test_addr];

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_click(input int x, input int y);
    bus.mouse_xpos = 12'(x);
    bus.mouse_ypos = 12'(y);
    bus.mouse_left = 1'b1;
    tick();
    bus.mouse_left = 1'b0;
  endtask

  // Cycles after the click edge until pick_valid; 0 if the budget expires.
  task automatic wait_pick(input int budget, output int c_out);
    c_out = 0;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (bus.pick_valid === 1'b1) begin
        c_out = c;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) tab[i] = 2'b01;
    rst            = 1'b1;
    bus.en         = 1'b1;
    bus.mouse_left = 1'b0;
    bus.mouse_xpos = '0;
    bus.mouse_ypos = '0;
    bus.clear_pair = 1'b0;
    do_reset();

    chk("rst_test_addr",   int'(bus.test_addr),   0);
    chk("rst_pick_addr",   int'(bus.pick_addr),   0);
    chk("rst_pick_valid",  int'(bus.pick_valid),  0);
    chk("rst_pick_second", int'(bus.pick_second), 0);
    chk("rst_busy",        int'(bus.busy),        0);

    // Card 0 hit: test_addr after scan edge, pulse three edges after click
    do_click(60, 60);
    chk("c0_busy", int'(bus.busy), 1);
    tick();
    chk("c0_test_addr", int'(bus.test_addr), 1);
    chk("c0_pv_e1", int'(bus.pick_valid), 0);
    tick();
    chk("c0_pv_e2", int'(bus.pick_valid), 0);
    tick();
    chk("c0_pv_e3", int'(bus.pick_valid), 1);
    chk("c0_pick_addr", int'(bus.pick_addr), 1);
    chk("c0_pick_second", int'(bus.pick_second), 0);
    tick();
    chk("c0_pv_drop", int'(bus.pick_valid), 0);
    chk("c0_idle", int'(bus.busy), 0);

    // Card 7 first pick, then card 0 second pick, WAIT_CLEAR behaviour
    do_reset();
    do_click(200, 300);
    wait_pick(20, cyc);
    chk("c7_latency", cyc, 10);
    chk("c7_pick_addr", int'(bus.pick_addr), 8);
    chk("c7_pick_second", int'(bus.pick_second), 0);
    tick();
    do_click(60, 60);
    wait_pick(20, cyc);
    chk("pair_latency", cyc, 3);
    chk("pair_pick_second", int'(bus.pick_second), 1);
    chk("pair_pick_addr", int'(bus.pick_addr), 1);
    chk("wc_busy", int'(bus.busy), 1);
    do_click(200, 300);
    wait_pick(15, cyc);
    chk("wc_click_dropped", cyc, 0);
    chk("wc_busy_held", int'(bus.busy), 1);
    bus.clear_pair = 1'b1;
    tick();
    bus.clear_pair = 1'b0;
    chk("wc_cleared", int'(bus.busy), 0);
    do_click(60, 60);
    wait_pick(20, cyc);
    chk("after_clear_latency", cyc, 3);
    chk("after_clear_second", int'(bus.pick_second), 0);
    // clear_pair outside WAIT_CLEAR must not reset the pair phase
    bus.clear_pair = 1'b1;
    tick();
    bus.clear_pair = 1'b0;
    tick();
    do_click(200, 300);
    wait_pick(20, cyc);
    chk("stray_clear_latency", cyc, 10);
    chk("stray_clear_second", int'(bus.pick_second), 1);

    // Click in the gap between cards 0 and 1: full scan, no pick
    do_reset();
    do_click(155, 60);
    pv_cnt = 0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (bus.pick_valid === 1'b1) pv_cnt++;
    end
    chk("gap_busy_c17", int'(bus.busy), 1);
    tick();
    chk("gap_busy_c18", int'(bus.busy), 0);
    tick();
    chk("gap_busy_c19", int'(bus.busy), 0);
    chk("gap_no_pick", pv_cnt, 0);
    chk("gap_test_addr", int'(bus.test_addr), 0);

    // Face-up card rejected; held button must not retrigger
    do_reset();
    tab[1] = 2'b11;
    bus.mouse_xpos = 12'd60;
    bus.mouse_ypos = 12'd60;
    bus.mouse_left = 1'b1;
    busy_cnt = 0;
    pv_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.pick_valid === 1'b1) pv_cnt++;
    end
    bus.mouse_left = 1'b0;
    tab[1] = 2'b01;
    chk("faceup_no_pick", pv_cnt, 0);
    chk("held_busy_cycles", busy_cnt, 2);
    tick();

    // Same card picked twice
    do_reset();
    do_click(60, 60);
    wait_pick(20, cyc);
    chk("same_first_latency", cyc, 3);
    tick();
    do_click(60, 60);
    wait_pick(10, cyc);
`ifdef CARD_CLICK_SAME_GUARD_EN
    chk("same_guard_no_pick", cyc, 0);
    chk("same_guard_idle", int'(bus.busy), 0);
`else
    chk("same_noguard_latency", cyc, 3);
    chk("same_noguard_second", int'(bus.pick_second), 1);
`endif

    // Asynchronous reset mid-scan, en drop in WAIT_CLEAR
    do_reset();
    do_click(60, 60);
    wait_pick(20, cyc);
    chk("ar_first_latency", cyc, 3);
    tick();
    do_click(200, 300);
    tick();
    tick();
    chk("ar_scanning", int'(bus.busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy",        int'(bus.busy),        0);
    chk("ar_test_addr",   int'(bus.test_addr),   0);
    chk("ar_pick_addr",   int'(bus.pick_addr),   0);
    chk("ar_pick_valid",  int'(bus.pick_valid),  0);
    chk("ar_pick_second", int'(bus.pick_second), 0);
    tick();
    rst = 1'b0;
    tick();
    do_click(60, 60);
    wait_pick(20, cyc);
    chk("ar_fresh_latency", cyc, 3);
    chk("ar_fresh_second", int'(bus.pick_second), 0);
    tick();
    do_click(200, 300);
    wait_pick(20, cyc);
    chk("en_second_latency", cyc, 10);
    chk("en_second_flag", int'(bus.pick_second), 1);
    tick();
    chk("en_wc_busy", int'(bus.busy), 1);
    bus.en = 1'b0;
    tick();
    chk("en_drop_busy", int'(bus.busy), 0);
    chk("en_drop_pick_addr", int'(bus.pick_addr), 8);
    chk("en_drop_pick_valid", int'(bus.pick_valid), 0);
    bus.en = 1'b1;
    tick();
    do_click(60, 60);
    wait_pick(20, cyc);
    chk("en_fresh_latency", cyc, 3);
    chk("en_fresh_second", int'(bus.pick_second), 0);
    chk("en_fresh_addr", int'(bus.pick_addr), 1);

    // en low blocks click detection entirely
    tick();
    bus.en = 1'b0;
    do_click(60, 60);
    wait_pick(10, cyc);
    chk("en_low_no_pick", cyc, 0);
    chk("en_low_idle", int'(bus.busy), 0);
    bus.en = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
